// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with write-to-read bypass and a per-register
// pending scoreboard (set by reserve, cleared by port B writeback).
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_count,
    output logic              sb_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic wa_ok, wb_ok, rsv_ok, rsv_hit_wb;
    logic inc, dec, err_now;

    // Operations aimed at a hardwired zero register are dropped entirely.
    always_comb begin
        wa_ok      = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
        wb_ok      = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
        rsv_ok     = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
        rsv_hit_wb = rsv_ok && wb_ok && (rsv_addr == wb_addr);
        inc        = rsv_ok && !pending[rsv_addr];
        dec        = wb_ok && pending[wb_addr] && !rsv_hit_wb;
        err_now    = (rsv_ok && pending[rsv_addr] && !rsv_hit_wb)
                   || (wb_ok && !pending[wb_addr])
                   || (wa_ok && pending[wa_addr]);
    end

    // Later assignments win: port B over port A, reserve over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending    <= '0;
            busy_count <= '0;
            sb_err     <= 1'b0;
        end else begin
            if (wa_ok)  mem[wa_addr] <= wa_data;
            if (wb_ok)  mem[wb_addr] <= wb_data;
            if (wb_ok)  pending[wb_addr]  <= 1'b0;
            if (rsv_ok) pending[rsv_addr] <= 1'b1;
            busy_count <= busy_count + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
            if (err_now) sb_err <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] ra    [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    assign ra[0]    = rd_addr1;
    assign ra[1]    = rd_addr2;
    assign rd_data1 = rdata[0];
    assign rd_data2 = rdata[1];
    assign rd_busy1 = rbusy[0];
    assign rd_busy2 = rbusy[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = mem[ra[p]];
            rbusy[p] = pending[ra[p]];
            if (BYPASS != 0) begin
                if (wb_en && (wb_addr == ra[p])) begin
                    rdata[p] = wb_data;
                    if (!(rsv_en && (rsv_addr == ra[p]))) rbusy[p] = 1'b0;
                end else if (wa_en && (wa_addr == ra[p])) begin
                    rdata[p] = wa_data;
                end
            end
            if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: per-cycle vector table plus hand-written
// sequences for the full-reserve / mid-sequence reset case. A BYPASS=0 twin shares inputs.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wa_addr, wb_addr, rsv_addr;
    logic [31:0] wa_data, wb_data;
    logic        wa_en, wb_en, rsv_en;
    logic [31:0] rd_data1, rd_data2, nb_rd1, nb_rd2;
    logic        rd_busy1, rd_busy2, nb_b1, nb_b2;
    logic [5:0]  busy_count, nb_cnt;
    logic        sb_err, nb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_count(busy_count), .sb_err(sb_err)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd1), .rd_data2(nb_rd2),
        .rd_busy1(nb_b1), .rd_busy2(nb_b2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_count(nb_cnt), .sb_err(nb_err)
    );

    typedef struct {
        logic        rst;
        logic        wa_en;  logic [4:0] wa_addr;  logic [31:0] wa_data;
        logic        wb_en;  logic [4:0] wb_addr;  logic [31:0] wb_data;
        logic        rsv_en; logic [4:0] rsv_addr;
        logic [4:0]  ra1, ra2;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [5:0]  e_cnt;
        logic        e_err;
        logic [31:0] e_nb1;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
        wa_addr = 5'd0; wb_addr = 5'd0; rsv_addr = 5'd0;
        wa_data = 32'd0; wb_data = 32'd0;
    endtask

    initial begin
        // rst, wa(en,addr,data), wb(en,addr,data), rsv(en,addr), ra1, ra2 | rd1, rd2, b1, b2, cnt, err, nb_rd1
        vecs[0]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd0,5'd1,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1,5'd0,32'hDEADBEEF,   1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd0,5'd0,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd7,  5'd0,5'd7,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd7,5'd0,   32'h0,32'h0,               1'b1,1'b0, 6'd1,1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b1,5'd7,32'hCAFE0007,   1'b0,5'd0,  5'd7,5'd0,   32'hCAFE0007,32'h0,        1'b0,1'b0, 6'd1,1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd9,  5'd7,5'd9,   32'hCAFE0007,32'h0,        1'b0,1'b0, 6'd0,1'b0, 32'hCAFE0007};
        vecs[6]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b1,5'd9,32'h99,         1'b1,5'd9,  5'd9,5'd7,   32'h99,32'hCAFE0007,       1'b1,1'b0, 6'd1,1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b1,5'd9,32'h9A,         1'b1,5'd10, 5'd9,5'd10,  32'h9A,32'h0,              1'b0,1'b0, 6'd1,1'b0, 32'h99};
        vecs[8]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b1,5'd10,32'h10,        1'b0,5'd0,  5'd9,5'd10,  32'h9A,32'h10,             1'b0,1'b0, 6'd1,1'b0, 32'h9A};
        vecs[9]  = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd5,  5'd10,5'd9,  32'h10,32'h9A,             1'b0,1'b0, 6'd0,1'b0, 32'h10};
        vecs[10] = '{1'b0, 1'b1,5'd5,32'h11111111,   1'b1,5'd5,32'h22222222,   1'b0,5'd0,  5'd5,5'd5,   32'h22222222,32'h22222222, 1'b0,1'b0, 6'd1,1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd5,5'd7,   32'h22222222,32'hCAFE0007, 1'b0,1'b0, 6'd0,1'b1, 32'h22222222};
        vecs[12] = '{1'b0, 1'b0,5'd0,32'h0,          1'b1,5'd3,32'h33,         1'b0,5'd0,  5'd5,5'd3,   32'h0,32'h33,              1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd3,5'd5,   32'h33,32'h0,              1'b0,1'b0, 6'd0,1'b1, 32'h33};
        vecs[14] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd4,  5'd3,5'd4,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd4,  5'd4,5'd3,   32'h0,32'h0,               1'b1,1'b0, 6'd1,1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd4,5'd0,   32'h0,32'h0,               1'b1,1'b0, 6'd1,1'b1, 32'h0};
        vecs[17] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b1,5'd6,  5'd6,5'd4,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[18] = '{1'b0, 1'b1,5'd6,32'h66,         1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd6,5'd0,   32'h66,32'h0,              1'b1,1'b0, 6'd1,1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd6,5'd0,   32'h66,32'h0,              1'b1,1'b0, 6'd1,1'b1, 32'h66};
        vecs[20] = '{1'b1, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd6,5'd6,   32'h66,32'h66,             1'b1,1'b1, 6'd1,1'b1, 32'h66};
        vecs[21] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd6,5'd7,   32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};
        vecs[22] = '{1'b0, 1'b0,5'd0,32'h0,          1'b0,5'd0,32'h0,          1'b0,5'd0,  5'd9,5'd10,  32'h0,32'h0,               1'b0,1'b0, 6'd0,1'b0, 32'h0};

        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            reset   = vecs[i].rst;
            wa_en   = vecs[i].wa_en;  wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en   = vecs[i].wb_en;  wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            rsv_en  = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
            rd_addr1 = vecs[i].ra1;   rd_addr2 = vecs[i].ra2;
            #1;
            chk($sformatf("v%0d rd_data1", i), rd_data1, vecs[i].e_rd1);
            chk($sformatf("v%0d rd_data2", i), rd_data2, vecs[i].e_rd2);
            chk($sformatf("v%0d rd_busy1", i), {31'd0, rd_busy1}, {31'd0, vecs[i].e_b1});
            chk($sformatf("v%0d rd_busy2", i), {31'd0, rd_busy2}, {31'd0, vecs[i].e_b2});
            chk($sformatf("v%0d busy_count", i), {26'd0, busy_count}, {26'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d sb_err", i), {31'd0, sb_err}, {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d nobypass rd_data1", i), nb_rd1, vecs[i].e_nb1);
            chk($sformatf("v%0d nobypass busy_count", i), {26'd0, nb_cnt}, {26'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d nobypass sb_err", i), {31'd0, nb_err}, {31'd0, vecs[i].e_err});
        end

        // Fill the scoreboard (r0 reserve must be ignored), then reset mid-sequence.
        @(negedge clk);
        idle();
        wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'h12121212;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            idle();
            rsv_en = 1'b1; rsv_addr = 5'(a);
        end
        @(negedge clk);
        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd31;
        #1;
        chk("full busy_count", {26'd0, busy_count}, 32'd31);
        chk("full sb_err", {31'd0, sb_err}, 32'd0);
        chk("full r0 busy", {31'd0, rd_busy1}, 32'd0);
        chk("full r31 busy", {31'd0, rd_busy2}, 32'd1);
        rd_addr1 = 5'd12;
        #1;
        chk("full r12 data", rd_data1, 32'h12121212);

        @(negedge clk);
        idle();
        reset = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd1;
        wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'h0000FFFF;
        @(negedge clk);
        idle();
        #1;
        chk("post-reset busy_count", {26'd0, busy_count}, 32'd0);
        chk("post-reset sb_err", {31'd0, sb_err}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            #1;
            chk($sformatf("post-reset r%0d data", a), rd_data1, 32'h0);
            chk($sformatf("post-reset r%0d busy", a), {31'd0, rd_busy1}, 32'd0);
            chk($sformatf("post-reset nobypass r%0d data", 31 - a), nb_rd2, 32'h0);
            chk($sformatf("post-reset nobypass r%0d busy", a), {30'd0, nb_b1, nb_b2}, 32'd0);
        end

        // A late load arriving after the scoreboard was wiped is a protocol error.
        @(negedge clk);
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3;
        @(negedge clk);
        idle();
        #1;
        chk("stale wb sb_err", {31'd0, sb_err}, 32'd1);
        chk("stale wb busy_count", {26'd0, busy_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
